// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and output requantization for the MLP layer-1 accumulator.
// sat_relu maps a signed accumulator to an unsigned activation: shift, clamp negatives, saturate.
package mlp_pkg;

    localparam int N1    = 98;
    localparam int N2    = 10;
    localparam int W_K   = 4;
    localparam int W_X   = 8;
    localparam int W_ACC = 20;
    localparam int W_Y   = 8;
    localparam int SHIFT = 4;

    localparam int HALF  = N1 / 2;
    localparam int KW    = $clog2(N1);
    localparam int KROW  = $clog2(HALF);
    localparam int W_P   = W_X + W_K;
    localparam int Y_MAX = (2 ** W_Y) - 1;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    function automatic logic [W_Y-1:0] sat_relu(input logic signed [W_ACC-1:0] acc);
        logic signed [W_ACC-1:0] r;
        logic [W_Y-1:0]          y;
        r = acc >>> SHIFT;
        if (r[W_ACC-1]) begin
            y = {W_Y{1'b0}};
        end else if (r > $signed(W_ACC'(Y_MAX))) begin
            y = {W_Y{1'b1}};
        end else begin
            y = r[W_Y-1:0];
        end
        return y;
    endfunction

endpackage

// File: rtl/mlp_layer1_mac_lane.sv
// One hidden-neuron lane: unsigned pixel times signed weight, sign-extended into a
// registered accumulator. Clear wins over enable, though the two never coincide in use.
module mac_lane
    import mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic [W_X-1:0]          i_x,
    input  logic [W_K-1:0]          i_w,
    output logic signed [W_ACC-1:0] o_acc
);

    logic signed [W_P-1:0]   w_x_ext;
    logic signed [W_P-1:0]   w_w_ext;
    logic signed [W_P-1:0]   w_prod;
    logic signed [W_ACC-1:0] w_prod_ext;
    logic signed [W_ACC-1:0] r_acc;

    // Both operands widened to the product width so the multiply is exact and signed
    assign w_x_ext    = $signed({{W_K{1'b0}}, i_x});
    assign w_w_ext    = $signed({{W_X{i_w[W_K-1]}}, i_w});
    assign w_prod     = w_x_ext * w_w_ext;
    assign w_prod_ext = $signed({{(W_ACC-W_P){w_prod[W_P-1]}}, w_prod});

    // Accumulator register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= {W_ACC{1'b0}};
        end else if (i_clr) begin
            r_acc <= {W_ACC{1'b0}};
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mlp_layer1_mac.sv
// Layer-1 hidden accumulator: streams N1 pixels into N2 parallel MAC lanes, then holds the
// requantized activation vector on a valid/ready port until downstream accepts it.
module mlp_layer1_mac
    import mlp_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [HALF-1:0][N2-1:0][W_K-1:0]      weights_n1_mag,
    input  logic [HALF-1:0][N2-1:0][W_K-1:0]      weights_n1_pol,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [W_X-1:0]                        s_data,
    input  logic                                  s_last,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [N2-1:0][W_Y-1:0]                m_data,
    output logic                                  err_len
);

    state_t                  r_state;
    logic [KW-1:0]           r_k;
    logic                    r_err_len;

    logic                    w_accept;
    logic                    w_at_end;
    logic                    w_close;
    logic                    w_clr;
    logic                    w_sel_pol;
    logic [KROW-1:0]         w_row;
    logic signed [W_ACC-1:0] w_acc [N2];

    assign s_ready  = (r_state == S_ACC);
    assign m_valid  = (r_state == S_OUT);
    assign err_len  = r_err_len;

    assign w_accept = s_valid & s_ready;
    assign w_at_end = (r_k == KW'(N1 - 1));
    assign w_close  = w_accept & (w_at_end | s_last);
    assign w_clr    = m_valid & m_ready;

    // First half of the frame reads the mag table, second half the pol table
    always_comb begin
        w_sel_pol = 1'b0;
        w_row     = {KROW{1'b0}};
        if (r_k < KW'(HALF)) begin
            w_sel_pol = 1'b0;
            w_row     = r_k[KROW-1:0];
        end else begin
            w_sel_pol = 1'b1;
            w_row     = KROW'(r_k - KW'(HALF));
        end
    end

    // Frame state: accumulate until close, then hold output until accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_ACC;
        end else begin
            case (r_state)
                S_ACC:   r_state <= w_close ? S_OUT : S_ACC;
                S_OUT:   r_state <= m_ready ? S_ACC : S_OUT;
                default: r_state <= S_ACC;
            endcase
        end
    end

    // Beat counter within the current frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_k <= {KW{1'b0}};
        end else if (w_close) begin
            r_k <= {KW{1'b0}};
        end else if (w_accept) begin
            r_k <= r_k + KW'(1);
        end else begin
            r_k <= r_k;
        end
    end

    // Length error: s_last disagrees with the beat count at close
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_len <= 1'b0;
        end else begin
            r_err_len <= w_close & (w_at_end ^ s_last);
        end
    end

    for (genvar j = 0; j < N2; j++) begin : g_lane
        logic [W_K-1:0] w_w;

        assign w_w = w_sel_pol ? weights_n1_pol[w_row][j] : weights_n1_mag[w_row][j];

        mac_lane u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .i_en  (w_accept),
            .i_clr (w_clr),
            .i_x   (s_data),
            .i_w   (w_w),
            .o_acc (w_acc[j])
        );

        assign m_data[j] = sat_relu(w_acc[j]);
    end

endmodule
